mul_ctrl: RTL

Execute-stage initiator for the iterative multiplier. It accepts RV32M multiply requests (MUL, MULH, MULHSU, MULHU) from the EX stage and drives the multiplier's start/cancel/signed/operand handshake. It stalls the pipeline while the multiplier runs and converts the 64-bit product into the 32-bit architectural result, including the MULHSU sign correction. On a pipeline flush it aborts the multiplier with a cancel pulse.

---
 rtl/mul_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mul_ctrl.sv
// mul_ctrl: execute-stage initiator for the iterative multiplier.
//
// Takes RV32M multiply requests (MUL, MULH, MULHSU, MULHU) from EX and runs
// the start/cancel handshake with the multiplier. It stalls the pipeline
// while the multiplier works. It folds the 64-bit product into the 32-bit
// result, including the MULHSU sign correction. A flush while busy aborts
// the multiplier with a one-cycle cancel pulse.
//
// Optional feature: define MUL_CTRL_REUSE_EN to add a single-entry
// operand/product cache. A request that repeats the previous operands and
// signedness completes without starting the multiplier.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid_i, req_op_i     request strobe and op (00 MUL, 01 MULH,
//                             10 MULHSU, 11 MULHU)
//   req_op1_i, req_op2_i      rs1 / rs2 values
//   flush_i                   kill the current instruction
//   stall_o                   hold EX and upstream (combinational)
//   res_valid_o, res_o        one-cycle result strobe (combinational), result
//   mul_start_o               held high until mul_stop_i
//   mul_cancel_o              one-cycle abort pulse
//   mul_signed_o              1 = signed x signed
//   mul_op1_o, mul_op2_o      latched operands
//   mul_stop_i                multiplier done
//   mul_res_l_i, mul_res_h_i  product low / high words
//
// state | meaning
// IDLE  | waiting for a request; accepts on req_valid_i && !flush_i
// BUSY  | multiplier running; waits for mul_stop_i or flush_i
// DONE  | result presented for one cycle; always returns to IDLE
module mul_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  input  logic [1:0]      req_op_i,
  input  logic [XLEN-1:0] req_op1_i,
  input  logic [XLEN-1:0] req_op2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            res_valid_o,
  output logic [XLEN-1:0] res_o,
  output logic            mul_start_o,
  output logic            mul_cancel_o,
  output logic            mul_signed_o,
  output logic [XLEN-1:0] mul_op1_o,
  output logic [XLEN-1:0] mul_op2_o,
  input  logic            mul_stop_i,
  input  logic [XLEN-1:0] mul_res_l_i,
  input  logic [XLEN-1:0] mul_res_h_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  state_t            state;
  logic [1:0]        op_q;
  logic              req_go;
  logic              want_signed;
  logic              reuse_hit;
  logic [XLEN-1:0]   hit_res;
  logic [2*XLEN-1:0] prod_in;

  assign req_go      = req_valid_i && !flush_i;
  assign want_signed = (req_op_i == OP_MULH);
  assign prod_in     = {mul_res_h_i, mul_res_l_i};

  // MULHSU runs unsigned x unsigned. Treating a negative rs1 as unsigned
  // adds rs2 * 2^32 to the product, so rs2 is subtracted from the high
  // word to recover the signed x unsigned result.
  function automatic logic [XLEN-1:0] fold(input logic [1:0]        op,
                                           input logic [XLEN-1:0]   a,
                                           input logic [XLEN-1:0]   b,
                                           input logic [2*XLEN-1:0] p);
    logic [XLEN-1:0] hi;
    hi = p[2*XLEN-1:XLEN];
    case (op)
      OP_MUL:    fold = p[XLEN-1:0];
      OP_MULHSU: fold = hi - (a[XLEN-1] ? b : '0);
      default:   fold = hi;
    endcase
  endfunction

`ifdef MUL_CTRL_REUSE_EN
  logic              e_valid;
  logic              e_signed;
  logic [XLEN-1:0]   e_op1;
  logic [XLEN-1:0]   e_op2;
  logic [2*XLEN-1:0] e_prod;

  assign reuse_hit = e_valid && (e_op1 == req_op1_i) && (e_op2 == req_op2_i) &&
                     (e_signed == want_signed);
  assign hit_res   = fold(req_op_i, req_op1_i, req_op2_i, e_prod);

  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid  <= 1'b0;
      e_signed <= 1'b0;
      e_op1    <= '0;
      e_op2    <= '0;
      e_prod   <= '0;
    end else if (state == BUSY) begin
      if (flush_i) begin
        e_valid <= 1'b0;
      end else if (mul_stop_i) begin
        e_valid  <= 1'b1;
        e_signed <= mul_signed_o;
        e_op1    <= mul_op1_o;
        e_op2    <= mul_op2_o;
        e_prod   <= prod_in;
      end
    end
  end
`else
  assign reuse_hit = 1'b0;
  assign hit_res   = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      op_q         <= OP_MUL;
      mul_start_o  <= 1'b0;
      mul_cancel_o <= 1'b0;
      mul_signed_o <= 1'b0;
      mul_op1_o    <= '0;
      mul_op2_o    <= '0;
      res_o        <= '0;
    end else begin
      mul_cancel_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_go) begin
            op_q         <= req_op_i;
            mul_op1_o    <= req_op1_i;
            mul_op2_o    <= req_op2_i;
            mul_signed_o <= want_signed;
            if (reuse_hit) begin
              res_o <= hit_res;
              state <= DONE;
            end else begin
              mul_start_o <= 1'b1;
              state       <= BUSY;
            end
          end
        end
        BUSY: begin
          // A flush takes priority over a completion in the same cycle.
          if (flush_i) begin
            mul_start_o  <= 1'b0;
            mul_cancel_o <= 1'b1;
            state        <= IDLE;
          end else if (mul_stop_i) begin
            mul_start_o <= 1'b0;
            res_o       <= fold(op_q, mul_op1_o, mul_op2_o, prod_in);
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_o     = (state == BUSY) || ((state == IDLE) && req_go);
  assign res_valid_o = (state == DONE) && !flush_i;

endmodule
